// File: rtl/pll_lock_sequencer_pkg.sv
// pll_seq_pkg: state codes and helpers shared by the PLL lock sequencer, its debug logic and bench.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      ST_PLLRST   = 3'd0,
      ST_WAITLOCK = 3'd1,
      ST_STABLE   = 3'd2,
      ST_RUN      = 3'd3,
      ST_LOST     = 3'd4,
      ST_FAIL     = 3'd5
   } state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync2.sv
// sync2: two-flop synchronizer for a single asynchronous input, cleared to 0 by reset.
//   i_clk   destination clock
//   i_rst_n asynchronous active-low reset
//   i_d     asynchronous input
//   o_q     synchronized output (2 cycles latency)
module sync2 (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= 1'b0;
         r_q    <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_q    <= r_meta;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: brings up the SB_PLL40 after power-up or lock loss and releases the design reset.
//   i_clock         board reference clock (also feeds the PLL), so sequencing survives an unlocked PLL
//   i_reset_n       asynchronous active-low reset
//   i_pll_lock      PLL LOCK, asynchronous to i_clock
//   i_relock_req    single-cycle request to restart the whole sequence and clear retries/fail
//   o_pll_resetb    PLL RESETB (0 = PLL held in reset)
//   o_pll_gate      PLL LATCHINPUTVALUE (1 = PLL output gated)
//   o_sys_reset_n   design reset for the PLL clock domain (0 = held)
//   o_ready         high only in RUN once o_sys_reset_n is released
//   o_fail          sticky failure flag
//   o_retry_count   retries consumed, saturating at MAX_RETRIES
//   o_state         current state code for debug
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int RESET_CYCLES  = 16,
   parameter int LOCK_TIMEOUT  = 4096,
   parameter int STABLE_CYCLES = 1024,
   parameter int LOSS_FILTER   = 4,
   parameter int MAX_RETRIES   = 3,
   localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
   input  logic          i_clock,
   input  logic          i_reset_n,
   input  logic          i_pll_lock,
   input  logic          i_relock_req,
   output logic          o_pll_resetb,
   output logic          o_pll_gate,
   output logic          o_sys_reset_n,
   output logic          o_ready,
   output logic          o_fail,
   output logic [RW-1:0] o_retry_count,
   output logic [2:0]    o_state
);

   localparam int CW = $clog2(max3(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);
   localparam int LW = (LOSS_FILTER > 1) ? $clog2(LOSS_FILTER) : 1;

   localparam logic [CW-1:0] RST_LAST  = CW'(RESET_CYCLES - 1);
   localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STAB_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_FILTER - 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

   state_t        r_state;
   state_t        w_next;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt;
   logic [LW-1:0] r_loss;
   logic [LW-1:0] w_loss;
   logic [1:0]    r_rel;
   logic [1:0]    w_rel;
   logic [RW-1:0] r_retry;
   logic [RW-1:0] w_retry;
   logic          r_resetb;
   logic          r_gate;
   logic          r_sys;
   logic          r_ready;
   logic          r_fail;
   logic          w_lock_s;
   logic          w_exh;
   logic          w_entry;
   logic          w_counting;
   logic          w_release;

   sync2 u_sync_lock (
      .i_clk   (i_clock),
      .i_rst_n (i_reset_n),
      .i_d     (i_pll_lock),
      .o_q     (w_lock_s)
   );

   assign w_exh = r_retry == RETRY_MAX;

   // Retry branches go to FAIL once exhausted, so the increment never overflows MAX_RETRIES.
   always_comb begin
      w_next  = r_state;
      w_retry = r_retry;
      case (r_state)
         ST_PLLRST:   w_next = (r_cnt == RST_LAST) ? ST_WAITLOCK : ST_PLLRST;
         ST_WAITLOCK: begin
            if (w_lock_s) w_next = ST_STABLE;
            else if (r_cnt == LOCK_LAST) begin
               w_next  = w_exh ? ST_FAIL : ST_PLLRST;
               w_retry = w_exh ? r_retry : r_retry + RW'(1);
            end
         end
         ST_STABLE:   w_next = !w_lock_s ? ST_WAITLOCK : (r_cnt == STAB_LAST) ? ST_RUN : ST_STABLE;
         ST_RUN:      w_next = (!w_lock_s && r_loss == LOSS_LAST) ? ST_LOST : ST_RUN;
         ST_LOST: begin
            w_next  = w_exh ? ST_FAIL : ST_PLLRST;
            w_retry = w_exh ? r_retry : r_retry + RW'(1);
         end
         ST_FAIL:     w_next = ST_FAIL;
         default:     w_next = ST_PLLRST;
      endcase
      if (i_relock_req) begin
         w_next  = ST_PLLRST;
         w_retry = '0;
      end
   end

   // A relock counts as a fresh entry even when already in PLLRST, so counting restarts.
   assign w_entry    = (w_next != r_state) || i_relock_req;
   assign w_counting = r_state inside {ST_PLLRST, ST_WAITLOCK, ST_STABLE};
   assign w_cnt      = (w_entry || !w_counting) ? '0 : r_cnt + CW'(1);
   assign w_loss     = (w_entry || r_state != ST_RUN || w_lock_s) ? '0 : r_loss + LW'(1);
   assign w_rel      = (w_entry || r_state != ST_RUN) ? 2'd0 : (r_rel == 2'd2) ? 2'd2 : r_rel + 2'd1;
   // Design reset is released on the second edge after RUN entry, giving the ungated clock time to settle.
   assign w_release  = (w_next == ST_RUN) && (w_rel == 2'd2);

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state  <= ST_PLLRST;
         r_cnt    <= '0;
         r_loss   <= '0;
         r_rel    <= 2'd0;
         r_retry  <= '0;
         r_resetb <= 1'b0;
         r_gate   <= 1'b1;
         r_sys    <= 1'b0;
         r_ready  <= 1'b0;
         r_fail   <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_cnt    <= w_cnt;
         r_loss   <= w_loss;
         r_rel    <= w_rel;
         r_retry  <= w_retry;
         r_resetb <= !(w_next == ST_PLLRST || w_next == ST_FAIL);
         r_gate   <= w_next != ST_RUN;
         r_sys    <= w_release;
         r_ready  <= w_release;
         r_fail   <= w_next == ST_FAIL;
      end
   end

   assign o_pll_resetb  = r_resetb;
   assign o_pll_gate    = r_gate;
   assign o_sys_reset_n = r_sys;
   assign o_ready       = r_ready;
   assign o_fail        = r_fail;
   assign o_retry_count = r_retry;
   assign o_state       = r_state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: scoreboard bench; every change of the output vector is matched against a queued expectation.
module tb_pll_lock_sequencer;
   import pll_seq_pkg::*;

   typedef struct {
      logic [9:0] v;
      int         c;
   } exp_t;

   // Output vector layout: {state[2:0], resetb, gate, sys_reset_n, ready, fail, retry[1:0]}
   localparam logic [9:0] RST_V = {ST_PLLRST, 5'b01000, 2'd0};

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic       lock   = 1'b0;
   logic       relock = 1'b0;
   logic       resetb;
   logic       gate;
   logic       sys;
   logic       ready;
   logic       fail;
   logic [1:0] retry;
   logic [2:0] st;
   int         cyc   = 0;
   int         base  = 0;
   int         total = 0;
   int         bad   = 0;
   exp_t       q[$];
   logic [9:0] last_exp;
   logic [9:0] prev = '1;
   logic [9:0] obs;
   exp_t       e;

   pll_lock_sequencer #(
      .RESET_CYCLES  (4),
      .LOCK_TIMEOUT  (32),
      .STABLE_CYCLES (8),
      .LOSS_FILTER   (3),
      .MAX_RETRIES   (2)
   ) dut (
      .i_clock       (clk),
      .i_reset_n     (rst_n),
      .i_pll_lock    (lock),
      .i_relock_req  (relock),
      .o_pll_resetb  (resetb),
      .o_pll_gate    (gate),
      .o_sys_reset_n (sys),
      .o_ready       (ready),
      .o_fail        (fail),
      .o_retry_count (retry),
      .o_state       (st)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [9:0] vv(input state_t s, input logic [4:0] flags, input logic [1:0] r);
      return {s, flags, r};
   endfunction

   task automatic push_abs(input int c, input logic [9:0] v);
      exp_t x;
      x.v = v;
      x.c = c;
      q.push_back(x);
      last_exp = v;
   endtask

   task automatic push(input int n, input logic [9:0] v);
      push_abs(base + n, v);
   endtask

   task automatic at(input int n);
      while (cyc < base + n) @(negedge clk);
   endtask

   task automatic apply_reset();
      if (last_exp != RST_V) push_abs(cyc, RST_V);
      rst_n  = 1'b0;
      lock   = 1'b0;
      relock = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      base  = cyc;
   endtask

   initial begin
      forever begin
         @(negedge clk or negedge rst_n);
         #1;
         obs = {st, resetb, gate, sys, ready, fail, retry};
         if (obs != prev) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_change: cyc=%0d got=%b required=no change", cyc, obs);
            end else begin
               e = q.pop_front();
               if (obs != e.v || (e.c >= 0 && cyc != e.c)) begin
                  bad++;
                  $display("FAIL step: got vec=%b at cyc=%0d, required vec=%b at cyc=%0d", obs, cyc, e.v, e.c);
               end
            end
            prev = obs;
         end
      end
   end

   initial begin
      push_abs(-1, RST_V);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      base  = cyc;

      // clean lock, 2-cycle glitch ignored, 3-cycle loss -> LOST -> PLLRST with retry 1
      push(4,  vv(ST_WAITLOCK, 5'b11000, 2'd0));
      at(9);  lock = 1'b1;
      push(12, vv(ST_STABLE,   5'b11000, 2'd0));
      push(20, vv(ST_RUN,      5'b10000, 2'd0));
      push(22, vv(ST_RUN,      5'b10110, 2'd0));
      at(30); lock = 1'b0;
      at(32); lock = 1'b1;
      at(40); lock = 1'b0;
      push(45, vv(ST_LOST,     5'b11000, 2'd0));
      push(46, vv(ST_PLLRST,   5'b01000, 2'd1));
      push(50, vv(ST_WAITLOCK, 5'b11000, 2'd1));
      at(52); apply_reset();

      // unstable lock: bounce STABLE <-> WAITLOCK, never RUN, no retry consumed
      push(4, vv(ST_WAITLOCK, 5'b11000, 2'd0));
      for (int k = 0; k < 4; k++) begin
         at(9 + 10 * k); lock = 1'b1;
         push(12 + 10 * k, vv(ST_STABLE,   5'b11000, 2'd0));
         push(17 + 10 * k, vv(ST_WAITLOCK, 5'b11000, 2'd0));
         at(14 + 10 * k); lock = 1'b0;
      end
      at(50); apply_reset();

      // no lock: two timeouts then FAIL; relock clears; relock on the timeout edge wins
      push(4,   vv(ST_WAITLOCK, 5'b11000, 2'd0));
      push(36,  vv(ST_PLLRST,   5'b01000, 2'd1));
      push(40,  vv(ST_WAITLOCK, 5'b11000, 2'd1));
      push(72,  vv(ST_PLLRST,   5'b01000, 2'd2));
      push(76,  vv(ST_WAITLOCK, 5'b11000, 2'd2));
      push(108, vv(ST_FAIL,     5'b01001, 2'd2));
      at(112); relock = 1'b1;
      push(113, vv(ST_PLLRST,   5'b01000, 2'd0));
      push(117, vv(ST_WAITLOCK, 5'b11000, 2'd0));
      at(113); relock = 1'b0;
      at(148); relock = 1'b1;
      push(149, vv(ST_PLLRST,   5'b01000, 2'd0));
      push(153, vv(ST_WAITLOCK, 5'b11000, 2'd0));
      at(149); relock = 1'b0;
      at(155); apply_reset();

      // asynchronous reset mid-RUN: outputs return to reset values before the next edge
      push(4,  vv(ST_WAITLOCK, 5'b11000, 2'd0));
      at(9);  lock = 1'b1;
      push(12, vv(ST_STABLE,   5'b11000, 2'd0));
      push(20, vv(ST_RUN,      5'b10000, 2'd0));
      push(22, vv(ST_RUN,      5'b10110, 2'd0));
      at(25);
      @(posedge clk);
      #2;
      push_abs(cyc, RST_V);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #2;

      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL pending_expectations: got %0d left, required 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
